// File: rtl/jt51_i2s_pkg.sv
// Types, constants and helpers shared by the JT51 I2S transmitter files.
package jt51_i2s_pkg;
`include "jt51_i2s_defs.vh"

   localparam int BIT_W = $clog2(FRAME_BITS);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
   localparam logic [BIT_W-1:0] LR_START = BIT_W'(SLOT_W - 1);

   // One stereo sample; left sits in the upper half so the pair shifts out MSB first.
   typedef struct packed {
      logic [SLOT_W-1:0] l;
      logic [SLOT_W-1:0] r;
   } stereo_t;

   // Word select for bit slot b. lrclk leads the data by one bclk, so the right
   // word is announced at b=15 and the next left word already at b=31.
   function automatic logic lr_for_bit(input logic [BIT_W-1:0] b);
      lr_for_bit = (b >= LR_START) && (b != LAST_BIT);
   endfunction
endpackage

// File: rtl/jt51_i2s_clkgen.sv
// Bit clock generator: divides cen-qualified clk by 2*DIV and flags the bclk falling event.
module jt51_i2s_clkgen #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic cen_i,
   output logic bclk_o,
   output logic fall_evt_o
);
   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   logic [7:0] div_q;
   logic [7:0] div_d;
   logic       bclk_q;
   logic       bclk_d;
   logic       wrap_s;

   assign wrap_s     = cen_i && (div_q == DIV_LAST);
   // The falling event is the enabled cycle in which a high bclk is about to toggle.
   assign fall_evt_o = wrap_s && bclk_q;
   assign bclk_o     = bclk_q;

   // Next-state: count enabled cycles and toggle bclk each time the divider wraps.
   always_comb begin
      div_d  = div_q;
      bclk_d = bclk_q;
      if (cen_i) begin
         if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            bclk_d = ~bclk_q;
         end else begin
            div_d  = div_q + 8'd1;
         end
      end else begin
         div_d  = div_q;
         bclk_d = bclk_q;
      end
   end

   // Divider and bclk state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= 8'd0;
         bclk_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bclk_q <= bclk_d;
      end
   end
endmodule

// File: rtl/jt51_i2s_defs.vh
// Shared I2S framing constants: one stereo frame of two 16-bit slots.
`ifndef JT51_I2S_DEFS_VH
`define JT51_I2S_DEFS_VH
localparam int FRAME_BITS = 32;
localparam int SLOT_W     = 16;
`endif

// File: rtl/jt51_i2s_tx.sv
// Philips I2S transmitter for the JT51 accumulator: holding register, frame shifter and status flags.
module jt51_i2s_tx #(
   parameter int unsigned DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic        sample_stb,
   input  logic [15:0] left,
   input  logic [15:0] right,
   input  logic        clr,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        frame_stb,
   output logic        overrun,
   output logic        underrun
);
   import jt51_i2s_pkg::*;

   logic                  fall_s;
   logic                  load_s;
   logic                  stb_s;

   logic [BIT_W-1:0]      b_q;
   logic [BIT_W-1:0]      b_d;
   stereo_t               hold_q;
   stereo_t               hold_d;
   logic [FRAME_BITS-1:0] shift_q;
   logic [FRAME_BITS-1:0] shift_d;
   logic                  fresh_q;
   logic                  fresh_d;
   logic                  lrclk_q;
   logic                  lrclk_d;
   logic                  sdata_q;
   logic                  sdata_d;
   logic                  frame_stb_q;
   logic                  frame_stb_d;
   logic                  overrun_q;
   logic                  overrun_d;
   logic                  underrun_q;
   logic                  underrun_d;

   jt51_i2s_clkgen #(.DIV(DIV)) u_clkgen (
      .clk        (clk),
      .rst        (rst),
      .cen_i      (cen),
      .bclk_o     (bclk),
      .fall_evt_o (fall_s)
   );

   assign stb_s  = cen && sample_stb;
   // A new frame enters the shifter when the bit counter wraps 31 -> 0.
   assign load_s = fall_s && (b_q == LAST_BIT);

   // Next-state: framing on falling events, sample capture and sticky status.
   always_comb begin
      b_d         = b_q;
      hold_d      = hold_q;
      shift_d     = shift_q;
      fresh_d     = fresh_q;
      lrclk_d     = lrclk_q;
      sdata_d     = sdata_q;
      frame_stb_d = frame_stb_q;
      overrun_d   = overrun_q;
      underrun_d  = underrun_q;
      if (cen) begin
         frame_stb_d = load_s;
         if (fall_s) begin
            b_d = b_q + 5'd1;
            // The shifter takes the holding value present before this cycle's strobe.
            if (load_s) begin
               shift_d = hold_q;
            end else begin
               shift_d = shift_q;
            end
            lrclk_d = lr_for_bit(b_d);
            sdata_d = shift_d[LAST_BIT - b_d];
         end else begin
            b_d = b_q;
         end
         // A strobe always lands in holding; a coincident load has already taken the old value.
         if (stb_s) begin
            hold_d.l = left;
            hold_d.r = right;
            fresh_d  = 1'b1;
         end else if (load_s) begin
            fresh_d  = 1'b0;
         end else begin
            fresh_d  = fresh_q;
         end
         if (clr) begin
            overrun_d  = 1'b0;
            underrun_d = 1'b0;
         end else begin
            overrun_d  = overrun_q;
            underrun_d = underrun_q;
         end
         // Set events win over clr. A strobe coinciding with a load loses nothing, so no overrun.
         if (load_s && !fresh_q) begin
            underrun_d = 1'b1;
         end else begin
            underrun_d = underrun_d;
         end
         if (stb_s && fresh_q && !load_s) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_d;
         end
      end else begin
         frame_stb_d = frame_stb_q;
      end
   end

   // Framing and status registers with synchronous reset that abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_q         <= LAST_BIT;
         hold_q      <= '0;
         shift_q     <= '0;
         fresh_q     <= 1'b0;
         lrclk_q     <= 1'b0;
         sdata_q     <= 1'b0;
         frame_stb_q <= 1'b0;
         overrun_q   <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         b_q         <= b_d;
         hold_q      <= hold_d;
         shift_q     <= shift_d;
         fresh_q     <= fresh_d;
         lrclk_q     <= lrclk_d;
         sdata_q     <= sdata_d;
         frame_stb_q <= frame_stb_d;
         overrun_q   <= overrun_d;
         underrun_q  <= underrun_d;
      end
   end

   assign lrclk     = lrclk_q;
   assign sdata     = sdata_q;
   assign frame_stb = frame_stb_q;
   assign overrun   = overrun_q;
   assign underrun  = underrun_q;
endmodule
